serial_port: RTL

Memory-mapped 8N1 UART that sits on the CPU's I/O side, directly downstream of the CPU's device strobes. It consumes the MAR address, the shared 16-bit bus and the DI/DO device strobes. It buffers transmit bytes and receive bytes in small FIFOs so that the microcoded CPU never waits on the serial line. The CPU polls the block by status register; the block raises no interrupts.

---
 rtl/serial_port_if.sv | 11 +
 rtl/serial_port.sv | 132 +++++++++++++
 2 files changed

// File: rtl/serial_port_if.sv
// serial_port_if: CPU device-side bus (address, data, DI/DO strobes, read-back)
interface serial_port_if;
  logic [15:0] addr;
  logic [15:0] bus_in;
  logic [15:0] bus_out;
  logic        DI;
  logic        DO;
  logic        bus_oe;
  modport master (output addr, bus_in, DI, DO, input bus_out, bus_oe);
  modport slave (input addr, bus_in, DI, DO, output bus_out, bus_oe);
endinterface

// File: rtl/serial_port.sv
// serial_port: memory-mapped 8N1 UART with TX/RX FIFOs and a polled status register
module serial_port #(
  parameter logic [15:0] BASE = 16'd136,
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  serial_port_if.slave bus,
  input  logic rx,
  output logic tx
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic sel_data, sel_stat, rd_data, rd_stat, wr_data, unused_hi;
  logic [15:0] status;
  logic [7:0] tx_mem [DEPTH];
  logic [AW-1:0] tx_wr, tx_rd;
  logic [AW:0] tx_cnt;
  logic tx_empty, tx_full, tx_push, tx_pop, tx_busy;
  state_t tx_st;
  logic [CW-1:0] tx_clk;
  logic [2:0] tx_bit;
  logic [7:0] tx_sh;
  logic [7:0] rx_mem [DEPTH];
  logic [AW-1:0] rx_wr, rx_rd;
  logic [AW:0] rx_cnt;
  logic rx_empty, rx_full, rx_push, rx_pop, rx_done;
  logic rx_s1, rx_s2, rx_ovr, rx_ferr;
  state_t rx_st;
  logic [CW-1:0] rx_clk;
  logic [2:0] rx_bit;
  logic [7:0] rx_sh;
  assign sel_data = bus.addr == BASE;
  assign sel_stat = bus.addr == BASE + 16'd1;
  assign rd_data = bus.DO & sel_data;
  assign rd_stat = bus.DO & sel_stat;
  assign wr_data = bus.DI & sel_data;
  assign unused_hi = &bus.bus_in[15:8];
  assign tx_empty = tx_cnt == '0;
  assign tx_full = tx_cnt == FULL;
  assign tx_pop = ~tx_empty & (tx_st == IDLE | (tx_st == STOP & tx_clk == BIT_END));
  assign tx_push = wr_data & (~tx_full | tx_pop);
  assign tx_busy = ~tx_empty | tx_st != IDLE;
  assign rx_empty = rx_cnt == '0;
  assign rx_full = rx_cnt == FULL;
  assign rx_done = rx_st == STOP & rx_clk == BIT_END;
  assign rx_pop = rd_data & ~rx_empty;
  assign rx_push = rx_done & rx_s2 & (~rx_full | rx_pop);
  assign status = {11'd0, tx_busy, rx_ferr, rx_ovr, ~tx_full, ~rx_empty};
  assign bus.bus_oe = bus.DO & (sel_data | sel_stat);
  assign bus.bus_out = ~bus.bus_oe ? '0 : sel_stat ? status : rx_empty ? '0 : {8'h00, rx_mem[rx_rd]};
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= bus.bus_in[7:0];
    if (rx_push) rx_mem[rx_wr] <= rx_sh;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr <= '0;
      tx_rd <= '0;
      tx_cnt <= '0;
      rx_wr <= '0;
      rx_rd <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop) tx_rd <= tx_rd + 1'b1;
      tx_cnt <= tx_cnt + (AW + 1)'(tx_push) - (AW + 1)'(tx_pop);
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop) rx_rd <= rx_rd + 1'b1;
      rx_cnt <= rx_cnt + (AW + 1)'(rx_push) - (AW + 1)'(rx_pop);
    end
  end
  // tx is registered from the current state, so the line lags the FSM by one edge
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st <= IDLE;
      tx <= 1'b1;
      tx_clk <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
    end else begin
      tx <= tx_st == START ? 1'b0 : tx_st == DATA ? tx_sh[0] : 1'b1;
      tx_clk <= tx_st == IDLE || tx_clk == BIT_END ? '0 : tx_clk + 1'b1;
      if (tx_pop) tx_sh <= tx_mem[tx_rd];
      case (tx_st)
        IDLE: if (tx_pop) tx_st <= START;
        START: if (tx_clk == BIT_END) tx_st <= DATA;
        DATA:
          if (tx_clk == BIT_END) begin
            tx_sh <= tx_sh >> 1;
            tx_bit <= tx_bit + 1'b1;
            if (tx_bit == 3'd7) tx_st <= STOP;
          end
        default: if (tx_clk == BIT_END) tx_st <= tx_pop ? START : IDLE;
      endcase
    end
  end
  // a set event on the same edge as a status read wins over the read's clear
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_st <= IDLE;
      rx_clk <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_ovr <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      {rx_s2, rx_s1} <= {rx_s1, rx};
      rx_clk <= rx_st == IDLE || (rx_st == START ? rx_clk == HALF_END : rx_clk == BIT_END) ? '0 : rx_clk + 1'b1;
      rx_ovr <= (rx_done & rx_s2 & rx_full & ~rx_pop) | (rx_ovr & ~rd_stat);
      rx_ferr <= (rx_done & ~rx_s2) | (rx_ferr & ~rd_stat);
      case (rx_st)
        IDLE: if (!rx_s2) rx_st <= START;
        START: if (rx_clk == HALF_END) rx_st <= rx_s2 ? IDLE : DATA;
        DATA:
          if (rx_clk == BIT_END) begin
            rx_sh <= {rx_s2, rx_sh[7:1]};
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_st <= STOP;
          end
        default: if (rx_clk == BIT_END) rx_st <= IDLE;
      endcase
    end
  end
endmodule
